// File: rtl/if_fetch_queue.sv
// if_fetch_queue: DEPTH-entry {pc, instr} FIFO between instruction fetch and decode.
// Replaces the single-entry IF/ID register so IF keeps running while ID stalls.
// A flush (redirect) empties the queue. While nothing is valid, decode sees a NOP bubble.
// Optional feature: define IFQ_BYPASS_EN for a zero-latency path when the queue is empty.
module if_fetch_queue #(
  parameter int unsigned   DEPTH = 4,
  parameter int unsigned   IW    = 32,
  parameter int unsigned   PCW   = 32,
  parameter logic [IW-1:0] NOP   = IW'(32'h0000_0013),
  localparam int unsigned  AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [PCW-1:0] in_pc,
  input  logic [IW-1:0]  in_instr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PCW-1:0] out_pc,
  output logic [IW-1:0]  out_instr,
  output logic [AW:0]    count
);

  localparam logic [AW:0]   CountFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  // Storage is deliberately not reset; only pointers and occupancy are.
  logic [PCW-1:0] pc_mem    [DEPTH];
  logic [IW-1:0]  instr_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic empty, full;
  logic bypass;
  logic push, pop;
  logic wr_en, rd_adv;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountFull);
  assign count = count_q;

`ifdef IFQ_BYPASS_EN
  // Empty queue with both sides ready: hand the fetch straight to decode.
  assign bypass = empty & in_valid & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // Handshake flags; in_ready never looks at out_ready so a full queue stalls IF.
  always_comb begin
    in_ready  = ~full & ~flush;
    out_valid = (~empty & ~flush) | bypass;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    // A bypassed entry is consumed without touching storage or pointers.
    wr_en     = push & ~bypass;
    rd_adv    = pop & ~bypass;
  end

  // Head presentation: bypassed input, stored head, or the 0/NOP bubble.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (out_valid) begin
      out_pc    = pc_mem[rd_ptr_q];
      out_instr = instr_mem[rd_ptr_q];
    end
  end

  // Next-state for pointers and occupancy; flush overrides any push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      unique case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write at the tail on an accepted, non-bypassed push.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue (DEPTH=4): vector table plus scoreboard.
module tb_if_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [2:0]  cnt;

  if_fetch_queue #(.DEPTH(4), .IW(32), .PCW(32), .NOP(32'h0000_0013)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .count    (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    int          ecnt;  // expected count after the edge
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          m_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  function automatic vec_t mk(input logic f, input logic iv, input logic [31:0] pc,
                              input logic ordy, input int ecnt);
    vec_t v;
    v.f = f; v.iv = iv; v.pc = pc; v.ordy = ordy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one cycle, check combinational outputs against the model, then the edge result.
  task automatic step(input vec_t v);
    logic        byp, e_ir, e_ov, do_push, do_pop;
    logic [31:0] e_pc;
    @(negedge clk);
    flush     = v.f;
    in_valid  = v.iv;
    in_pc     = v.pc;
    in_instr  = instr_of(v.pc);
    out_ready = v.ordy;
    #1;
    byp  = BYP && (m_cnt == 0) && v.iv && v.ordy && !v.f;
    e_ir = (m_cnt != 4) && !v.f;
    e_ov = ((m_cnt != 0) && !v.f) || byp;
    chk("count_pre", 32'(cnt), 32'(m_cnt));
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (e_ov) begin
      e_pc = byp ? v.pc : ((sb.size() > 0) ? sb[0] : 32'hFFFF_FFFF);
      chk("out_pc", out_pc, e_pc);
      chk("out_instr", out_instr, instr_of(e_pc));
    end else begin
      chk("bubble_pc", out_pc, 32'h0);
      chk("bubble_instr", out_instr, NOP_I);
    end
    do_push = v.iv && e_ir;
    do_pop  = e_ov && v.ordy;
    if (v.f) begin
      sb.delete();
      m_cnt = 0;
    end else if (!byp) begin
      if (do_pop && sb.size() > 0) void'(sb.pop_front());
      if (do_push) sb.push_back(v.pc);
      m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("count_post", 32'(cnt), 32'(v.ecnt));
  endtask

  initial begin
    // Fill to full, refused offer, full+pop (no push), drain in order.
    vecs.push_back(mk(0, 1, 32'h00, 0, 1));
    vecs.push_back(mk(0, 1, 32'h04, 0, 2));
    vecs.push_back(mk(0, 1, 32'h08, 0, 3));
    vecs.push_back(mk(0, 1, 32'h0C, 0, 4));
    vecs.push_back(mk(0, 1, 32'h10, 0, 4));
    vecs.push_back(mk(0, 1, 32'h14, 1, 3));
    vecs.push_back(mk(0, 0, 32'h0, 1, 2));
    vecs.push_back(mk(0, 0, 32'h0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0));
    // Simultaneous push+pop at count=2 for 8 cycles, wrapping both pointers.
    vecs.push_back(mk(0, 1, 32'h100, 0, 1));
    vecs.push_back(mk(0, 1, 32'h104, 0, 2));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(0, 1, 32'h108 + 32'(4 * k), 1, 2));
    vecs.push_back(mk(0, 0, 32'h0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0));
    // Flush at count=3 with an offer pending, then 0x40 is the next head.
    vecs.push_back(mk(0, 1, 32'h200, 0, 1));
    vecs.push_back(mk(0, 1, 32'h204, 0, 2));
    vecs.push_back(mk(0, 1, 32'h208, 0, 3));
    vecs.push_back(mk(1, 1, 32'h20C, 1, 0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0));
    // Decode stall for 3 cycles on head 0x20, then consumed once.
    vecs.push_back(mk(0, 1, 32'h20, 0, 1));
    vecs.push_back(mk(0, 1, 32'h24, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0));

    rst = 1'b0; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_instr = 0;
    #1;
    chk("rst_count", 32'(cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, NOP_I);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // Asynchronous reset mid-stream at count=3, checked between clock edges.
    step(mk(0, 1, 32'h300, 0, 1));
    step(mk(0, 1, 32'h304, 0, 2));
    step(mk(0, 1, 32'h308, 0, 3));
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #1 rst = 1'b0;
    #1;
    chk("arst_count", 32'(cnt), 32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_instr", out_instr, NOP_I);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    sb.delete();
    m_cnt = 0;
    #1 rst = 1'b1;
    step(mk(0, 1, 32'h310, 0, 1));
    step(mk(0, 0, 32'h0, 1, 0));

    // Empty queue, offer 0x80 with decode ready: same-cycle only with the bypass.
    step(mk(0, 1, 32'h80, 1, BYP ? 0 : 1));
    step(mk(0, 0, 32'h0, 1, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
